// File: rtl/dpram_burst_reader.sv
// Burst read engine for a dpram_2p read port: issues sequential reads, absorbs the RAM
// read latency and returns words in address order on a valid/ready stream.
module dpram_burst_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  rdreq,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + RD_LATENCY + 2) + 1;

    // Stream handshake: a word moves on any edge where m_valid & m_ready; m_valid never
    // drops and m_data never changes while the consumer stalls.

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  accepted;
    logic [RD_LATENCY-1:0] tag;
    logic [DATA_WIDTH-1:0] skid [SKID_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         in_use;
    logic                  push;
    logic                  pop;
    logic                  credit;
    logic                  issue;

    assign push      = tag[RD_LATENCY-1];
    assign m_valid   = (count != '0);
    assign pop       = m_valid & m_ready;
    assign m_data    = skid[rd_ptr];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Every word already requested, in the RAM pipe or buffered, holds one buffer slot.
    always_comb begin
        in_use = count + CW'(rdreq) - CW'(pop);
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_use = in_use + CW'(tag[i]);
        end
        credit = (in_use < CW'(SKID_DEPTH));
    end

    always_comb begin
        issue = 1'b0;
        if (state == IDLE) begin
            issue = start && (length != '0) && credit;
        end else if (state == RUN) begin
            issue = (issued != len_r) && credit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            rdreq    <= 1'b0;
            rdaddr   <= '0;
            base_r   <= '0;
            len_r    <= '0;
            issued   <= '0;
            accepted <= '0;
        end else begin
            done  <= 1'b0;
            rdreq <= issue;
            if (pop) begin
                accepted <= accepted + LEN_WIDTH'(1);
            end
            if (issue) begin
                rdaddr <= (state == IDLE) ? base_addr : base_r + issued[ADDR_WIDTH-1:0];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            base_r   <= base_addr;
                            len_r    <= length;
                            accepted <= '0;
                            issued   <= issue ? LEN_WIDTH'(1) : '0;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issued <= issued + LEN_WIDTH'(1);
                    end else if (issued == len_r) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (accepted == len_r - LEN_WIDTH'(1))) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid[i] <= '0;
            end
        end else begin
            tag[0] <= rdreq;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            if (push) begin
                skid[wr_ptr] <= q;
                wr_ptr       <= (wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CW'(SKID_DEPTH))));

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Bench for dpram_burst_reader: behavioural RAM, word/address scoreboards fed by the
// driver, and a negedge monitor that checks stream, address, done and credit behaviour.
module tb_dpram_burst_reader;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LW = AW + 1;
    localparam int SD = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          rdreq;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] q;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [1:0]    dbg_state;

    dpram_burst_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(2), .SKID_DEPTH(SD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .rdreq(rdreq), .rdaddr(rdaddr), .q(q),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural two-stage RAM read port
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ram_a;
    logic          ram_v;
    initial begin
        q     = '0;
        ram_v = 1'b0;
        ram_a = '0;
    end
    always @(posedge clk) begin
        ram_v <= rdreq;
        if (rdreq) ram_a <= rdaddr;
        if (ram_v) q <= mem[ram_a];
    end

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            checks;
    int            errors;
    bit            done_due;
    int            issued_seen;
    int            popped_seen;
    bit            held;
    logic [DW-1:0] held_data;
    int            ready_low_pct;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition violated at %0t", name, $time);
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (done || done_due) check("done_pulse", done, done_due);
            done_due = 1'b0;
            if (rdreq) begin
                issued_seen++;
                if (exp_addr_q.size() == 0) fail("rdreq_spurious");
                else check("rdaddr", rdaddr, exp_addr_q.pop_front());
                check("outstanding_le_depth", (issued_seen - popped_seen) <= SD, 1);
            end
            if (held) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_data", m_data, held_data);
                held = 1'b0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_valid");
                end else if (m_ready) begin
                    check("m_data", m_data, exp_q.pop_front());
                    popped_seen++;
                    if (exp_q.size() == 0) done_due = 1'b1;
                end else begin
                    held      = 1'b1;
                    held_data = m_data;
                end
            end
        end
    end

    // consumer ready generator
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 99) >= ready_low_pct);
        end
    end

    // driver: caller sits just after a posedge with the DUT idle
    task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
        end
        start     = 1'b1;
        base_addr = b;
        length    = l;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = LW'($urandom);
        if (l == '0) done_due = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) fail("wait_idle_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        checks = 0;
        errors = 0;
        done_due = 1'b0;
        issued_seen = 0;
        popped_seen = 0;
        held = 1'b0;
        ready_low_pct = 0;
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rdreq", rdreq, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_rdaddr", rdaddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // base 5, len 8, full rate: latency and throughput
        start_burst(6'd5, 7'd8);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_start", busy, 1);
            if (n == 3) check("m_valid_before_latency", m_valid, 0);
            if (n == 4) check("m_valid_at_latency", m_valid, 1);
            if (done) break;
        end
        check("burst_cycles", n, 12);
        @(posedge clk);
        #1;
        wait_idle(100);

        // wrap around the top of the address space
        start_burst(6'd60, 7'd8);
        wait_idle(200);

        // zero length
        start_burst(6'd17, 7'd0);
        repeat (4) @(posedge clk);
        #1;
        check("len0_idle", busy, 0);
        wait_idle(50);

        // start while busy must be ignored
        start_burst(6'd10, 7'd12);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 6'd40;
        length = 7'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(200);

        // asynchronous reset mid-burst, then a clean burst
        start_burst(6'd7, 7'd12);
        p0 = popped_seen;
        n = 0;
        while ((popped_seen - p0) < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail("reset_test_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_rdreq", rdreq, 0);
        check("async_m_valid", m_valid, 0);
        check("async_rdaddr", rdaddr, 0);
        check("async_m_data", m_data, 0);
        exp_q.delete();
        exp_addr_q.delete();
        done_due = 1'b0;
        held = 1'b0;
        issued_seen = 0;
        popped_seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_burst(6'd0, 7'd4);
        wait_idle(100);

        // randomized data, backpressure and lengths
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        ready_low_pct = 30;
        start_burst(AW'($urandom), 7'd16);
        wait_idle(500);
        for (int k = 0; k < 12; k++) begin
            start_burst(AW'($urandom), LW'($urandom_range(0, 20)));
            wait_idle(500);
        end
        start_burst(AW'($urandom), 7'd64);
        wait_idle(1000);

        ready_low_pct = 0;
        repeat (5) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
